// File: rtl/prog_timer_n.sv
// Multi-channel programmable clock divider with per-channel output shaping.
// Channels are loaded over a narrow write bus: a control word, then NB count beats.
module prog_timer_n #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned CW      = 8,
  parameter int unsigned DW      = 4,
  parameter int unsigned MIN_CNT = 2,
  parameter int unsigned MAX_CNT = 2**CW - 1,
  localparam int unsigned AW     = $clog2(NCH) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we,
  input  logic [AW-1:0]  a,
  input  logic [DW-1:0]  d,
  input  logic [NCH-1:0] g,
  output logic [NCH-1:0] out,
  output logic           busy,
  output logic           err
);

  localparam int unsigned NB  = CW / DW;
  localparam int unsigned BW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned CHW = (AW > 1) ? AW - 1 : 1;

  typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_t;

  state_t         state, state_n;
  logic [BW-1:0]  beat, beat_n;
  logic [CHW-1:0] sel, sel_n;
  logic [2:0]     mode_s, mode_s_n;
  logic [CW-1:0]  shadow, shadow_n;
  logic           commit, err_n;

  logic [CHW-1:0] a_ch;
  logic           last_beat;
  logic [CW-1:0]  n_new;
  logic [CW:0]    n_ext;
  logic           range_ok, par_ok, n_ok;

  // Channel index field with the control/beat select bit masked off.
  assign a_ch      = CHW'(a & ~(AW'(1) << (AW - 1)));
  assign last_beat = (beat == BW'(NB - 1));
  assign n_new     = CW'({shadow, d});
  assign n_ext     = {1'b0, n_new};

  // Count validation against range and mode parity rules.
  always_comb begin
    range_ok = (n_ext >= (CW+1)'(MIN_CNT)) && (n_ext <= (CW+1)'(MAX_CNT));
    par_ok   = 1'b0;
    case (mode_s)
      3'd0, 3'd1, 3'd5: par_ok = 1'b1;
      3'd2:             par_ok = ~n_new[0];
      3'd3, 3'd4:       par_ok = n_new[0];
      default:          par_ok = 1'b0;
    endcase
    n_ok = range_ok && par_ok;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      beat   <= '0;
      sel    <= '0;
      mode_s <= '0;
      shadow <= '0;
      busy   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      beat   <= beat_n;
      sel    <= sel_n;
      mode_s <= mode_s_n;
      shadow <= shadow_n;
      busy   <= (state_n == LOAD);
      err    <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    beat_n   = beat;
    sel_n    = sel;
    mode_s_n = mode_s;
    shadow_n = shadow;
    commit   = 1'b0;
    err_n    = 1'b0;
    case (state)
      IDLE: begin
        if (we && a[AW-1]) begin
          sel_n    = a_ch;
          mode_s_n = d[2:0];
          beat_n   = '0;
          shadow_n = '0;
          state_n  = LOAD;
        end
      end
      LOAD: begin
        if (we) begin
          if (a == AW'(sel)) begin
            shadow_n = n_new;
            if (last_beat) begin
              state_n = IDLE;
              commit  = n_ok;
              err_n   = ~n_ok;
            end else begin
              beat_n = beat + 1'b1;
            end
          end else begin
            // Any foreign address, including another control write, aborts.
            state_n = IDLE;
            err_n   = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CW-1:0] cnt_q, max_r;
    logic [2:0]    mode_r;
    logic          cfg_r, gq_r, hit, dec, o;
    logic [CW:0]   c, m;

    assign hit = commit && (sel == CHW'(i));
    assign c   = {1'b0, cnt_q};
    assign m   = {1'b0, max_r};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q  <= '0;
        max_r  <= '0;
        mode_r <= '0;
        cfg_r  <= 1'b0;
        gq_r   <= 1'b0;
      end else begin
        gq_r <= g[i];
        if (hit) begin
          max_r  <= n_new;
          mode_r <= mode_s;
          cfg_r  <= 1'b1;
          cnt_q  <= (mode_s == 3'd5) ? '0 : n_new;
        end else if (cfg_r) begin
          if (mode_r == 3'd5) begin
            if (g[i] && !gq_r)    cnt_q <= max_r;
            else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          end else if (g[i]) begin
            cnt_q <= (cnt_q == CW'(1)) ? max_r : cnt_q - 1'b1;
          end
        end
      end
    end

    // Output shaping decode, evaluated one bit wider than the counter.
    always_comb begin
      dec = 1'b0;
      o   = 1'b0;
      case (mode_r)
        3'd0:    dec = (c == m);
        3'd1:    dec = (c != m);
        3'd2:    dec = (c <= (m >> 1));
        3'd3:    dec = (c > ((m + 1'b1) >> 1));
        3'd4:    dec = (c <= ((m - 1'b1) >> 1));
        default: dec = 1'b0;
      endcase
      if (mode_r == 3'd5) o = cfg_r && (c != '0);
      else                o = dec && g[i] && cfg_r;
    end

    assign out[i] = o;
  end

endmodule

// File: tb/tb_prog_timer_n.sv
// Directed bench for prog_timer_n (NCH=4, CW=8, DW=4).
module tb_prog_timer_n;

  logic       clk, rst, we;
  logic [2:0] a;
  logic [3:0] d;
  logic [3:0] g;
  logic [3:0] out;
  logic       busy, err;

  int n_checks = 0;
  int n_errors = 0;

  logic [23:0] v;
  logic [23:0] b;
  logic        eacc;

  prog_timer_n #(.NCH(4), .CW(8), .DW(4)) dut (
    .clk(clk), .rst(rst), .we(we), .a(a), .d(d), .g(g),
    .out(out), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] aa, input logic [3:0] dd);
    we = 1'b1; a = aa; d = dd;
    tick();
    we = 1'b0; a = '0; d = '0;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; a = '0; d = '0; g = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", 32'(out), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    rst = 1'b0;
    tick();

    // Reset in the middle of a ch1 load.
    wr(3'b101, 4'h0);
    check("ctl_busy", 32'(busy), 32'h1);
    wr(3'b001, 4'h0);
    check("beat0_busy", 32'(busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_busy", 32'(busy), 32'h0);
    check("async_err", 32'(err), 32'h0);
    check("async_out", 32'(out), 32'h0);
    tick();
    rst = 1'b0;
    g = 4'b0010;
    repeat (3) tick();
    check("rst_ch1_out", 32'(out[1]), 32'h0);
    g = 4'b0000;

    // ch0 mode 0, n=4 (gate held low for now).
    wr(3'b100, 4'h0); wr(3'b000, 4'h0); wr(3'b000, 4'h4);
    check("ch0_err", 32'(err), 32'h0);
    check("ch0_busy", 32'(busy), 32'h0);

    // ch2 mode 2, n=10: 5 low then 5 high.
    wr(3'b110, 4'h2); wr(3'b010, 4'h0); wr(3'b010, 4'hA);
    check("ch2_err", 32'(err), 32'h0);
    g[2] = 1'b1;
    eacc = 1'b0; v = '0;
    for (int k = 0; k < 20; k++) begin
      #1;
      v[k] = out[2];
      eacc |= err;
      tick();
    end
    check("ch2_wave", 32'(v[19:0]), 32'hF83E0);
    check("ch2_no_err", 32'(eacc), 32'h0);
    g[2] = 1'b0;

    // ch0 mode 3, n=0x10 is even: rejected.
    wr(3'b100, 4'h3); wr(3'b000, 4'h1); wr(3'b000, 4'h0);
    check("rej_err", 32'(err), 32'h1);
    check("rej_busy", 32'(busy), 32'h0);
    tick();
    check("rej_err_1cyc", 32'(err), 32'h0);
    g[0] = 1'b1;
    v = '0;
    for (int k = 0; k < 8; k++) begin
      #1;
      v[k] = out[0];
      tick();
    end
    check("ch0_kept", 32'(v[7:0]), 32'h11);

    // Abort on wrong address, then an immediate new sequence.
    wr(3'b111, 4'h1); wr(3'b001, 4'h5);
    check("abort_err", 32'(err), 32'h1);
    check("abort_busy", 32'(busy), 32'h0);
    wr(3'b111, 4'h1);
    check("restart_busy", 32'(busy), 32'h1);
    check("restart_err", 32'(err), 32'h0);
    wr(3'b011, 4'h3); wr(3'b011, 4'h2);
    check("ch3_err", 32'(err), 32'h0);
    check("ch3_busy", 32'(busy), 32'h0);
    g[3] = 1'b1;
    #1;
    check("ch3_at_max", 32'(out[3]), 32'h0);
    tick();
    #1;
    check("ch3_below_max", 32'(out[3]), 32'h1);
    g[3] = 1'b0;

    // ch1 one-shot, n=3, with a retrigger.
    wr(3'b101, 4'h5); wr(3'b001, 4'h0); wr(3'b001, 4'h3);
    check("os_err", 32'(err), 32'h0);
    #1;
    check("os_idle", 32'(out[1]), 32'h0);
    g[1] = 1'b1;
    tick();
    g[1] = 1'b0;
    v = '0;
    for (int k = 0; k < 6; k++) begin
      #1;
      v[k] = out[1];
      tick();
    end
    check("os_pulse", 32'(v[5:0]), 32'h07);
    g[1] = 1'b1;
    tick();
    g[1] = 1'b0;
    v = '0;
    for (int k = 0; k < 7; k++) begin
      #1;
      v[k] = out[1];
      g[1] = (k == 1);
      tick();
    end
    check("os_retrig", 32'(v[6:0]), 32'h1F);
    g[1] = 1'b0;

    // Restart ch0 at a known phase, then load ch1 with stalls.
    wr(3'b100, 4'h0); wr(3'b000, 4'h0); wr(3'b000, 4'h4);
    v = '0; b = '0; eacc = 1'b0;
    for (int k = 0; k < 24; k++) begin
      #1;
      v[k] = out[0];
      b[k] = busy;
      eacc |= err;
      we = 1'b0; a = '0; d = '0;
      if (k == 2)      begin we = 1'b1; a = 3'b101; d = 4'h0; end
      else if (k == 5) begin we = 1'b1; a = 3'b001; d = 4'h0; end
      else if (k == 9) begin we = 1'b1; a = 3'b001; d = 4'h6; end
      tick();
    end
    we = 1'b0;
    check("stall_ch0", 32'(v), 32'h111111);
    check("stall_busy", 32'(b), 32'h0003F8);
    check("stall_err", 32'(eacc), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
